// File: rtl/ula_ctrl.sv
// Four-cycle sequencer (IDLE/READ/EXEC/WB) that fetches operands, drives the ULA and writes back.
// One instruction per 4 cycles; in_ready is high only in IDLE, and in_valid is ignored while busy.
module ula_ctrl #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_OPS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic [REG_AW-1:0] rf_ra,
  output logic [REG_AW-1:0] rf_rb,
  input  logic [DATA_W-1:0] rf_da,
  input  logic [DATA_W-1:0] rf_db,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [DATA_W-1:0] ula_a,
  output logic [DATA_W-1:0] ula_b,
  output logic [4:0]        ula_opcode,
  input  logic [DATA_W-1:0] ula_out,
  input  logic              ula_flag,
  output logic              flag,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0]        state;
  logic [31:0]       instr;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] res;
  logic              fl;
  logic [4:0]        opc;
  logic [4:0]        rd;
  logic [11:0]       imm12;
  logic              legal;
  logic              idle_accepting;

  assign opc   = instr[31:27];
  assign rd    = instr[26:22];
  assign imm12 = instr[11:0];
  assign legal = int'({28'd0, opc[3:0]}) < NUM_OPS;

  // Addresses come straight from the offered word in IDLE so the synchronous read lands in READ.
  assign idle_accepting = (state == S_IDLE) && in_valid && !reset;
  assign rf_ra = idle_accepting ? REG_AW'(in_instr[21:17]) : REG_AW'(instr[21:17]);
  assign rf_rb = idle_accepting ? REG_AW'(in_instr[16:12]) : REG_AW'(instr[16:12]);

  assign in_ready   = (state == S_IDLE);
  assign done       = (state == S_WB);
  assign err        = done && !legal;
  assign rf_we      = done && legal && (rd != 5'd0);
  assign rf_wa      = REG_AW'(rd);
  assign rf_wd      = res;
  assign ula_a      = op_a;
  assign ula_b      = op_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      instr      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      res        <= '0;
      fl         <= 1'b0;
      flag       <= 1'b0;
      ula_opcode <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            instr <= in_instr;
            state <= S_READ;
          end
        end
        S_READ: begin
          op_a       <= rf_da;
          op_b       <= opc[4] ? {{(DATA_W-12){imm12[11]}}, imm12} : rf_db;
          ula_opcode <= {1'b0, opc[3:0]};
          state      <= S_EXEC;
        end
        S_EXEC: begin
          res   <= ula_out;
          fl    <= ula_flag;
          state <= S_WB;
        end
        S_WB: begin
          // A write to r0 is suppressed but the flag still reflects the operation.
          if (legal) flag <= fl;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ula_ctrl.md
Name: ula_ctrl

Overview:
- Sequencer that drives the ULA as its initiator.
- Accepts one instruction word, reads two operands from the register file, and presents operands and opcode to the combinational ULA.
- Captures the ULA Out and Flag, then writes the result back to the register file.
- Sits between instruction issue and the ULA/register file in the Lapido datapath; each instruction takes 4 cycles.

Parameters:
- DATA_W, 32, datapath width (ULA A/B/Out, register data).
- REG_AW, 5, register-file address width.
- NUM_OPS, 16, count of legal ULA operations; base opcode values 0..NUM_OPS-1 are legal.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  controller can accept an instruction.
- in_instr  in  32  bit fields:
  - [31:27] opcode; opcode[4] = immediate form.
  - [26:22] rd.
  - [21:17] rs.
  - [16:12] rt.
  - [11:0] imm12.
- rf_ra  out  REG_AW  register-file read address A.
- rf_rb  out  REG_AW  register-file read address B.
- rf_da  in  DATA_W  read data A; valid 1 cycle after address (synchronous read).
- rf_db  in  DATA_W  read data B; same timing as rf_da.
- rf_we  out  1  write enable.
- rf_wa  out  REG_AW  write address.
- rf_wd  out  DATA_W  write data.
- ula_a  out  DATA_W  ULA operand A.
- ula_b  out  DATA_W  ULA operand B.
- ula_opcode  out  5  ULA opcode.
- ula_out  in  DATA_W  ULA result (combinational from ula_a/ula_b/ula_opcode).
- ula_flag  in  1  ULA flag (combinational).
- flag  out  1  registered flag from the last legal instruction.
- done  out  1  one-cycle pulse when an instruction retires.
- err  out  1  one-cycle pulse, coincident with done, for an illegal opcode.

Behaviour:
- Reset values (asynchronous, immediate): state=IDLE, in_ready=1, rf_we=0, done=0, err=0, flag=0. All address and data outputs are 0.
- States: IDLE -> READ -> EXEC -> WB -> IDLE. No other transitions except reset.
- IDLE:
  - in_ready=1.
  - On in_valid=1 (accept edge), latch in_instr.
  - Drive rf_ra=rs and rf_rb=rt combinationally from in_instr in the same cycle, so data returns in READ.
  - Go to READ.
  - With in_valid=0: stay in IDLE, outputs hold.
- READ:
  - in_ready=0.
  - Register opA=rf_da.
  - opB=rf_db if opcode[4]=0; otherwise opB = sign-extended imm12 to DATA_W, and rf_db is ignored.
  - Go to EXEC.
- EXEC:
  - ula_a=opA, ula_b=opB, ula_opcode={1'b0, opcode[3:0]}.
  - Register res=ula_out and fl=ula_flag at the end of the cycle.
  - Go to WB.
  - ula_a, ula_b and ula_opcode hold their last values outside EXEC.
- WB:
  - done=1.
  - Legal opcode (opcode[3:0] < NUM_OPS):
    - rf_we=1, rf_wa=rd, rf_wd=res.
    - flag updates to fl at the end of the cycle.
    - If rd==0, rf_we stays 0 (r0 is read-only); flag still updates.
  - Illegal opcode: rf_we=0, err=1, flag unchanged.
  - Go to IDLE.
- Latency: accepted at edge 0 -> rf_we and done high in cycle 3. Throughput: one instruction per 4 cycles.
- Back-to-back: in_ready is high again in the cycle after WB; no bubble beyond the 4-cycle occupancy.
- in_valid while busy is ignored; the source must hold the instruction until in_ready&&in_valid.
- Reset mid-instruction: the in-flight instruction is abandoned. No rf_we, no done, flag forced to 0.
- Sign-extension: imm12=12'hFFF -> opB=32'hFFFF_FFFF; imm12=12'h7FF -> opB=32'h0000_07FF.
- Read-after-write: a register written in WB is visible to the next instruction's READ. This is guaranteed by timing, because the next IDLE accept edge follows WB.

Test Plan:
- Reset, then R-type add: opcode=5'b00001, rd=3, rs=1, rt=2 with r1=5, r2=7, ULA model add -> in cycle 3: rf_we=1, rf_wa=3, rf_wd=12, done=1.
- Immediate form: opcode=5'b10001, rs=1 (r1=10), imm12=12'hFFF -> ula_b=32'hFFFF_FFFF, ula_opcode=5'b00001, rf_wd=9.
- rd=0 with a legal op whose model sets flag=1 -> done=1, rf_we stays 0, flag=1 after WB.
- Illegal opcode 5'b01111 with NUM_OPS=8 -> done=1, err=1, rf_we=0, flag unchanged.
- Two instructions with in_valid held high:
  - second accepted exactly 4 cycles after the first;
  - second reads the register written by the first and receives the new value.
- reset asserted during EXEC -> outputs immediately at reset values; no rf_we and no done afterward; next instruction after reset completes normally.
